serial_spi_slave: RTL and testbench
===================================

Name: serial_spi_slave

Overview:
- SPI slave front-end that drives the serial register file's parallel bus (data_wr, adr_in) and returns its data_rd.
- Converts 40-bit SPI frames from the test-stand host into single-cycle register writes, or into register reads whose data is shifted out on miso.
- Sits between the board SPI pins and the register file, in the `clock` domain.

Parameters:
- ADRSIZE, 7, register address width; header = 1 + ADRSIZE bits.
- REGSIZE, 32, data field width in bits.
- SYNC_STAGES, 2, flip-flop synchronizer depth on sclk, cs_n and mosi (minimum 2).

Ports:
- clock  in  1  system clock; must be at least 8x the sclk frequency.
- reset_n  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock (asynchronous input), mode 0.
- cs_n  in  1  SPI chip select, active low (asynchronous input).
- mosi  in  1  SPI data in, MSB first.
- miso  out  1  SPI data out, MSB first.
- miso_oe  out  1  miso output enable; high only while cs_n is low (synchronized).
- adr_in  out  ADRSIZE+1  to register file: [ADRSIZE] = wr strobe, [ADRSIZE-1:0] = address.
- data_wr  out  REGSIZE  write data to register file.
- data_rd  in  REGSIZE  read data from register file, combinational from adr_in.
- frame_cnt  out  16  count of completed frames (reads and writes); wraps at 0xFFFF -> 0.
- abort_cnt  out  16  count of frames with cs_n rising before bit 40; saturates at 0xFFFF.

Behaviour:
- Reset values:
  - adr_in = 0 (wr = 0, address 0).
  - data_wr = 0; miso = 0; miso_oe = 0.
  - frame_cnt = 0; abort_cnt = 0; FSM = IDLE.
  - Reset applies asynchronously at any time, including mid-frame. The frame in progress is discarded and no write is issued.
- Synchronization and edge detection:
  - sclk, cs_n and mosi pass through SYNC_STAGES flops.
  - A rise/fall pulse is formed from the last two synchronized sclk samples.
  - mosi is sampled at the synchronized sclk rise. miso changes at the synchronized sclk fall.
- Frame format, MSB first:
  - Bits 0..7: header, wr bit first, then adr[6:0].
  - Bits 8..39: data field.
  - Bits after 39 are ignored until cs_n rises.
- FSM states: IDLE, HDR, DATA, COMMIT, DONE.
  - IDLE: cs_n falls -> HDR. Clear bit counter and shift register; miso_oe = 1.
  - HDR: shift 8 bits. On the 8th rise:
    - adr_in[ADRSIZE-1:0] <= received address; adr_in[ADRSIZE] stays 0.
    - Record the wr flag internally.
    - -> DATA.
  - Read preload: if the wr flag = 0, load the tx shift register from data_rd exactly 2 clocks after adr_in updates (one settle cycle). This completes before the next sclk fall.
    - miso = tx[31] from the first data-phase sclk fall onward; shift left on each later fall.
    - Received mosi bits are discarded on reads.
  - DATA: shift 32 bits. On the 32nd rise, -> COMMIT if the wr flag = 1, else -> DONE.
  - COMMIT: data_wr <= received word and adr_in[ADRSIZE] <= 1 for exactly one clock, then adr_in[ADRSIZE] <= 0. -> DONE.
  - DONE: frame_cnt += 1 on entry. Wait for cs_n high -> IDLE; miso_oe = 0.
- Addressing rules:
  - adr_in address bits hold their last value between frames, so data_rd stays stable.
  - data_wr holds its last written value.
- Abort: cs_n rising in HDR or DATA -> IDLE.
  - No write strobe is issued.
  - abort_cnt += 1 (saturating at 0xFFFF).
  - miso_oe = 0.
- Simultaneous events:
  - If cs_n rises on the same synchronized clock as the 40th sclk rise, the frame counts as complete: the commit proceeds and there is no abort.
  - A new cs_n fall during COMMIT is queued: the FSM enters HDR the clock after DONE sees cs_n low, provided cs_n went high for at least one synchronized sample. Otherwise it stays in DONE.
- A write to an address beyond the register count is still strobed; the register file ignores it.

Decomposition:
- Shared package: frame length constants (HDR_BITS = 8, FRAME_BITS = 40), the FSM state enumeration, and the wr bit index (7).
- One sub-module, `sync_edge`: SYNC_STAGES synchronizer plus rise/fall pulse outputs. Instantiated for sclk and cs_n; mosi uses the synchronizer only.

Test Plan:
- Write frame, header 0x81 (wr, adr 1), data 0x00000025 -> exactly one clock with adr_in = 0x81 and data_wr = 0x25; then adr_in = 0x01; frame_cnt = 1.
- Read frame, header 0x05, with data_rd for adr 5 tied to 0xA5A5_1234 -> miso bits 8..39 equal 0xA5A51234 MSB first; no wr strobe; miso_oe high only during cs_n low.
- Write 0xDEADBEEF to adr 0, then read adr 0 with data_rd = loopback of data_wr -> miso returns 0xDEADBEEF.
- cs_n rises after 20 bits of a write frame -> no wr strobe; abort_cnt = 1; the next full frame completes normally.
- reset_n asserted at bit 30 of a write frame -> all outputs go to reset values immediately, no strobe; after release, the next frame works.
- 40 back-to-back frames with a 1-sample cs_n gap, sclk = clock/8 -> all commits correct; frame_cnt = 40; abort_cnt = 0.

Source files
------------

// File: rtl/serial_spi_slave_pkg.sv
// Shared frame constants and FSM state type for the SPI slave front-end.
// 40-bit frames: an 8-bit header (wr flag, then address) followed by a 32-bit data field.
package serial_spi_slave_pkg;

  localparam int HDR_BITS   = 8;
  localparam int FRAME_BITS = 40;
  localparam int WR_BIT     = 7;
  localparam int CNT_W      = 6;

  localparam logic [CNT_W-1:0] HDR_LAST   = CNT_W'(HDR_BITS - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    COMMIT,
    DONE
  } state_t;

endpackage

// File: rtl/serial_spi_slave_sync.sv
// Multi-flop synchronizer for one asynchronous input, with single-clock rise/fall
// pulses formed from the current and previous synchronized samples.
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_reg;
  logic              prev_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      chain_reg <= {STAGES{RESET_VAL}};
      prev_reg  <= RESET_VAL;
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], din};
      prev_reg  <= chain_reg[STAGES-1];
    end
  end

  assign sync = chain_reg[STAGES-1];
  assign rise = sync & ~prev_reg;
  assign fall = ~sync & prev_reg;

endmodule

// File: rtl/serial_spi_slave.sv
// SPI mode-0 slave that turns 40-bit frames into single-cycle register-file writes,
// or register reads whose data is shifted out on miso.
module serial_spi_slave
  import serial_spi_slave_pkg::*;
#(
  parameter int ADRSIZE     = 7,
  parameter int REGSIZE     = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               sclk,
  input  logic               cs_n,
  input  logic               mosi,
  output logic               miso,
  output logic               miso_oe,
  output logic [ADRSIZE:0]   adr_in,
  output logic [REGSIZE-1:0] data_wr,
  input  logic [REGSIZE-1:0] data_rd,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        abort_cnt
);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_chain_reg;
  logic mosi_sync;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (sclk),
    .sync    (sclk_sync),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (cs_n),
    .sync    (cs_sync),
    .rise    (cs_rise),
    .fall    (cs_fall)
  );

  // Same depth as sclk so the sampled bit lines up with the rise pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) mosi_chain_reg <= '0;
    else          mosi_chain_reg <= {mosi_chain_reg[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_sync = mosi_chain_reg[SYNC_STAGES-1];

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   bit_cnt_reg;
  logic [REGSIZE-1:0] rx_reg;
  logic [REGSIZE-1:0] tx_reg;
  logic               wr_flag_reg;
  logic [1:0]         preload_reg;
  logic               seen_high_reg;
  logic [ADRSIZE:0]   adr_reg;
  logic [REGSIZE-1:0] data_wr_reg;
  logic               miso_reg;
  logic               miso_oe_reg;
  logic [15:0]        frame_cnt_reg;
  logic [15:0]        abort_cnt_reg;

  logic [HDR_BITS-1:0] hdr_word;
  logic [REGSIZE-1:0]  rx_word;
  logic last_hdr_rise, last_data_rise;
  logic start_frame, abort, frame_end;

  assign rx_word        = {rx_reg[REGSIZE-2:0], mosi_sync};
  assign hdr_word       = rx_word[HDR_BITS-1:0];
  assign last_hdr_rise  = sclk_rise && (bit_cnt_reg == HDR_LAST);
  assign last_data_rise = sclk_rise && (bit_cnt_reg == FRAME_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // A frame that finishes on the same sample as cs_n rising is complete, not aborted.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cs_fall && !sclk_sync) state_next = HDR;
      HDR: begin
        if (cs_rise)            state_next = IDLE;
        else if (last_hdr_rise) state_next = DATA;
      end
      DATA: begin
        if (last_data_rise)     state_next = wr_flag_reg ? COMMIT : DONE;
        else if (cs_rise)       state_next = IDLE;
      end
      COMMIT:  state_next = DONE;
      DONE: begin
        if (cs_sync)            state_next = IDLE;
        else if (seen_high_reg) state_next = HDR;
      end
      default: state_next = IDLE;
    endcase
  end

  assign start_frame = (state_next == HDR) && (state_reg != HDR);
  assign abort       = ((state_reg == HDR) || (state_reg == DATA)) && (state_next == IDLE);
  assign frame_end   = (state_next == DONE) && (state_reg != DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_reg   <= '0;
      rx_reg        <= '0;
      tx_reg        <= '0;
      wr_flag_reg   <= 1'b0;
      preload_reg   <= 2'd0;
      seen_high_reg <= 1'b0;
      adr_reg       <= '0;
      data_wr_reg   <= '0;
      miso_reg      <= 1'b0;
      miso_oe_reg   <= 1'b0;
      frame_cnt_reg <= '0;
      abort_cnt_reg <= '0;
    end else begin
      adr_reg[ADRSIZE] <= 1'b0;

      if (start_frame) begin
        bit_cnt_reg   <= '0;
        rx_reg        <= '0;
        preload_reg   <= 2'd0;
        seen_high_reg <= 1'b0;
        miso_reg      <= 1'b0;
        miso_oe_reg   <= 1'b1;
      end else begin
        if (sclk_rise && ((state_reg == HDR) || (state_reg == DATA))) begin
          rx_reg      <= rx_word;
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end

        if ((state_reg == HDR) && (state_next == DATA)) begin
          adr_reg[ADRSIZE-1:0] <= hdr_word[ADRSIZE-1:0];
          wr_flag_reg          <= hdr_word[WR_BIT];
          preload_reg          <= hdr_word[WR_BIT] ? 2'd0 : 2'd2;
        end

        // One settle cycle after the address changes, then capture the read data.
        if (preload_reg == 2'd2) begin
          preload_reg <= 2'd1;
        end else if (preload_reg == 2'd1) begin
          preload_reg <= 2'd0;
          tx_reg      <= data_rd;
        end

        if ((state_reg == DATA) && sclk_fall && !wr_flag_reg) begin
          miso_reg <= tx_reg[REGSIZE-1];
          tx_reg   <= {tx_reg[REGSIZE-2:0], 1'b0};
        end

        if (state_reg == COMMIT) begin
          data_wr_reg      <= rx_reg;
          adr_reg[ADRSIZE] <= 1'b1;
        end

        if (cs_sync && ((state_reg == COMMIT) || ((state_reg == DATA) && last_data_rise)))
          seen_high_reg <= 1'b1;

        if (frame_end) frame_cnt_reg <= frame_cnt_reg + 16'd1;

        if (abort) begin
          miso_oe_reg <= 1'b0;
          if (abort_cnt_reg != 16'hFFFF) abort_cnt_reg <= abort_cnt_reg + 16'd1;
        end

        if ((state_reg == DONE) && (state_next == IDLE)) miso_oe_reg <= 1'b0;
      end
    end
  end

  assign adr_in    = adr_reg;
  assign data_wr   = data_wr_reg;
  assign miso      = miso_reg;
  assign miso_oe   = miso_oe_reg;
  assign frame_cnt = frame_cnt_reg;
  assign abort_cnt = abort_cnt_reg;

endmodule

// File: tb/tb_serial_spi_slave.sv
// Bench for serial_spi_slave: an SPI master driving sclk = clock/8, a simple register
// file on the parallel bus, and an expected-register model built from the stimulus.
module tb_serial_spi_slave;

  logic        clock;
  logic        reset_n;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  logic [7:0]  adr_in;
  logic [31:0] data_wr;
  logic [31:0] data_rd;
  logic [15:0] frame_cnt;
  logic [15:0] abort_cnt;

  serial_spi_slave dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .adr_in    (adr_in),
    .data_wr   (data_wr),
    .data_rd   (data_rd),
    .frame_cnt (frame_cnt),
    .abort_cnt (abort_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Register file seen by the DUT; address 5 can be tied to a fixed pattern.
  logic [31:0] rf [0:127] = '{default: 32'h0};
  logic        tie_adr5   = 1'b0;
  assign data_rd = (tie_adr5 && adr_in[6:0] == 7'd5) ? 32'hA5A5_1234 : rf[adr_in[6:0]];
  always @(posedge clock) if (adr_in[7]) rf[adr_in[6:0]] <= data_wr;

  // Expected register contents, updated only from the frames the bench sends.
  logic [31:0] exp_regs [0:127] = '{default: 32'h0};

  int          strobe_cnt = 0;
  logic [7:0]  last_adr   = '0;
  logic [31:0] last_data  = '0;
  int          cs_low_run = 0;
  int          cs_high_run = 0;
  int          oe_err     = 0;

  always @(negedge clock) begin
    if (!reset_n) begin
      cs_low_run  = 0;
      cs_high_run = 0;
    end else begin
      if (cs_n) begin cs_high_run++; cs_low_run = 0; end
      else      begin cs_low_run++;  cs_high_run = 0; end
      if ((miso_oe && cs_high_run > 4) || (!miso_oe && cs_low_run > 4)) oe_err++;
    end
    if (adr_in[7]) begin
      strobe_cnt++;
      last_adr  = adr_in;
      last_data = data_wr;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drives cs_n low and shifts out nbits; miso is captured just before each rise.
  task automatic spi_bits(input logic [39:0] bits, input int nbits, output logic [39:0] rx);
    rx   = '0;
    cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = bits[39-i];
      tick(4);
      rx[39-i] = miso;
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [39:0] bits, input int gap, output logic [39:0] rx);
    spi_bits(bits, 40, rx);
    tick(4);
    cs_n = 1'b1;
    tick(gap);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tick(4);
    checks++; if (adr_in !== 8'h00) begin failures++; $display("FAIL reset_adr_in: got %h want 00", adr_in); end
    checks++; if (data_wr !== 32'h0) begin failures++; $display("FAIL reset_data_wr: got %h want 0", data_wr); end
    checks++; if (miso !== 1'b0) begin failures++; $display("FAIL reset_miso: got %b want 0", miso); end
    checks++; if (miso_oe !== 1'b0) begin failures++; $display("FAIL reset_miso_oe: got %b want 0", miso_oe); end
    reset_n = 1'b1;
    tick(4);
    checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    checks++; if (abort_cnt !== 16'd0) begin failures++; $display("FAIL reset_abort_cnt: got %0d want 0", abort_cnt); end
    $display("reset: adr_in=%h frame_cnt=%0d abort_cnt=%0d", adr_in, frame_cnt, abort_cnt);
  endtask

  task automatic test_write;
    logic [39:0] rx;
    int s0 = strobe_cnt;
    spi_frame({8'h81, 32'h0000_0025}, 4, rx);
    exp_regs[1] = 32'h25;
    checks++; if (strobe_cnt - s0 != 1) begin failures++; $display("FAIL write_strobes: got %0d want 1", strobe_cnt - s0); end
    checks++; if (last_adr !== 8'h81) begin failures++; $display("FAIL write_adr: got %h want 81", last_adr); end
    checks++; if (last_data !== 32'h25) begin failures++; $display("FAIL write_data: got %h want 00000025", last_data); end
    checks++; if (adr_in !== 8'h01) begin failures++; $display("FAIL write_adr_after: got %h want 01", adr_in); end
    checks++; if (frame_cnt !== 16'd1) begin failures++; $display("FAIL write_frame_cnt: got %0d want 1", frame_cnt); end
    $display("write: adr=01 data=%h frame_cnt=%0d", last_data, frame_cnt);
  endtask

  task automatic test_read;
    logic [39:0] rx;
    logic [31:0] junk = $urandom;
    int s0 = strobe_cnt;
    tie_adr5 = 1'b1;
    spi_frame({8'h05, junk}, 4, rx);
    tie_adr5 = 1'b0;
    checks++; if (rx[31:0] !== 32'hA5A5_1234) begin failures++; $display("FAIL read_miso: got %h want a5a51234", rx[31:0]); end
    checks++; if (strobe_cnt != s0) begin failures++; $display("FAIL read_no_strobe: got %0d want 0", strobe_cnt - s0); end
    checks++; if (miso_oe !== 1'b0) begin failures++; $display("FAIL read_oe_after: got %b want 0", miso_oe); end
    checks++; if (oe_err != 0) begin failures++; $display("FAIL read_oe_window: got %0d want 0", oe_err); end
    checks++; if (frame_cnt !== 16'd2) begin failures++; $display("FAIL read_frame_cnt: got %0d want 2", frame_cnt); end
    $display("read: adr=05 miso=%h frame_cnt=%0d", rx[31:0], frame_cnt);
  endtask

  task automatic test_loopback;
    logic [39:0] rx;
    spi_frame({8'h80, 32'hDEAD_BEEF}, 4, rx);
    exp_regs[0] = 32'hDEAD_BEEF;
    spi_frame({8'h00, 32'h0}, 4, rx);
    checks++; if (rx[31:0] !== exp_regs[0]) begin failures++; $display("FAIL loopback_miso: got %h want %h", rx[31:0], exp_regs[0]); end
    checks++; if (frame_cnt !== 16'd4) begin failures++; $display("FAIL loopback_frame_cnt: got %0d want 4", frame_cnt); end
    $display("loopback: adr=00 miso=%h", rx[31:0]);
  endtask

  task automatic test_abort;
    logic [39:0] rx;
    logic [31:0] d = $urandom;
    int s0 = strobe_cnt;
    spi_bits({8'h82, 32'h1234_5678}, 20, rx);
    tick(4);
    cs_n = 1'b1;
    tick(8);
    checks++; if (strobe_cnt != s0) begin failures++; $display("FAIL abort_no_strobe: got %0d want 0", strobe_cnt - s0); end
    checks++; if (abort_cnt !== 16'd1) begin failures++; $display("FAIL abort_cnt: got %0d want 1", abort_cnt); end
    checks++; if (miso_oe !== 1'b0) begin failures++; $display("FAIL abort_oe: got %b want 0", miso_oe); end
    spi_frame({8'h82, d}, 4, rx);
    exp_regs[2] = d;
    checks++; if (last_adr !== 8'h82 || last_data !== d) begin failures++; $display("FAIL abort_next_write: got %h/%h want 82/%h", last_adr, last_data, d); end
    checks++; if (frame_cnt !== 16'd5) begin failures++; $display("FAIL abort_frame_cnt: got %0d want 5", frame_cnt); end
    $display("abort: abort_cnt=%0d next_data=%h", abort_cnt, last_data);
  endtask

  task automatic test_reset_mid_frame;
    logic [39:0] rx;
    logic [31:0] d = $urandom;
    int s0 = strobe_cnt;
    spi_bits({8'hB3, 32'h5555_AAAA}, 30, rx);
    reset_n = 1'b0;
    #1;
    checks++; if (adr_in !== 8'h00) begin failures++; $display("FAIL midreset_adr_in: got %h want 00", adr_in); end
    checks++; if (data_wr !== 32'h0) begin failures++; $display("FAIL midreset_data_wr: got %h want 0", data_wr); end
    checks++; if (miso_oe !== 1'b0 || miso !== 1'b0) begin failures++; $display("FAIL midreset_miso: got %b%b want 00", miso_oe, miso); end
    checks++; if (frame_cnt !== 16'd0 || abort_cnt !== 16'd0) begin failures++; $display("FAIL midreset_counts: got %0d/%0d want 0/0", frame_cnt, abort_cnt); end
    cs_n = 1'b1; sclk = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(3);
    checks++; if (strobe_cnt != s0) begin failures++; $display("FAIL midreset_no_strobe: got %0d want 0", strobe_cnt - s0); end
    spi_frame({8'hB3, d}, 4, rx);
    exp_regs[51] = d;
    checks++; if (last_adr !== 8'hB3 || last_data !== d) begin failures++; $display("FAIL midreset_next_write: got %h/%h want b3/%h", last_adr, last_data, d); end
    checks++; if (frame_cnt !== 16'd1) begin failures++; $display("FAIL midreset_frame_cnt: got %0d want 1", frame_cnt); end
    $display("reset_mid_frame: next write adr=33 data=%h", last_data);
  endtask

  task automatic test_back_to_back;
    logic [39:0] rx;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(2);
    for (int f = 0; f < 40; f++) begin
      logic        wr  = 1'($urandom_range(0, 1));
      logic [6:0]  adr = 7'($urandom_range(0, 127));
      logic [31:0] d   = $urandom;
      int          s0  = strobe_cnt;
      spi_frame({wr, adr, d}, 1, rx);
      if (wr) begin
        checks++;
        if (strobe_cnt - s0 != 1 || last_adr !== {1'b1, adr} || last_data !== d) begin
          failures++;
          $display("FAIL b2b_write[%0d]: got %0d strobes %h/%h want 1 strobe %h/%h",
                   f, strobe_cnt - s0, last_adr, last_data, {1'b1, adr}, d);
        end
        exp_regs[adr] = d;
        $display("b2b frame %0d: write adr=%h data=%h", f, adr, d);
      end else begin
        checks++;
        if (strobe_cnt != s0 || rx[31:0] !== exp_regs[adr]) begin
          failures++;
          $display("FAIL b2b_read[%0d]: got %0d strobes miso=%h want 0 strobes miso=%h",
                   f, strobe_cnt - s0, rx[31:0], exp_regs[adr]);
        end
        $display("b2b frame %0d: read adr=%h data=%h", f, adr, rx[31:0]);
      end
    end
    tick(8);
    checks++; if (frame_cnt !== 16'd40) begin failures++; $display("FAIL b2b_frame_cnt: got %0d want 40", frame_cnt); end
    checks++; if (abort_cnt !== 16'd0) begin failures++; $display("FAIL b2b_abort_cnt: got %0d want 0", abort_cnt); end
    checks++; if (oe_err != 0) begin failures++; $display("FAIL b2b_oe_window: got %0d want 0", oe_err); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_loopback();
    test_abort();
    test_reset_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
